// File: rtl/multicycle_left_shifter.sv
// Iterative logical left shifter (SLL). The shift amount is resolved one bit per
// cycle, most significant bit first: shift by 2**(SHAMT_W-1), ..., 2, 1.
// A new operation takes SHAMT_W cycles in SHIFT followed by one DONE cycle.
// The result register holds its value until the next operation completes.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request, sampled only in IDLE or DONE
//   flush    synchronous abort to IDLE; out keeps its value
//   data     operand, captured on the accepting edge
//   shamt    shift amount, captured on the accepting edge
//   busy     high while shifting
//   done     one-cycle pulse when out is new
//   out      result register
//
// WIDTH must equal 2**SHAMT_W.

module multicycle_left_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               flush,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    localparam int unsigned StageW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [StageW-1:0] LastStage = StageW'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e              state_q;
    logic [WIDTH-1:0]    acc_q;
    logic [SHAMT_W-1:0]  amt_q;
    logic [StageW-1:0]   stage_q;
    logic [WIDTH-1:0]    out_q;
    logic                busy_q;
    logic                done_q;

    logic [SHAMT_W-1:0]  step;
    logic [WIDTH-1:0]    acc_d;

    // 2**stage always fits in SHAMT_W bits because stage < SHAMT_W.
    always_comb begin
        step  = SHAMT_W'(1) << stage_q;
        acc_d = acc_q;
        if (amt_q[stage_q]) begin
            acc_d = acc_q << step;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            amt_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q   <= data;
                        amt_q   <= shamt;
                        stage_q <= LastStage;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    acc_q <= acc_d;
                    if (stage_q == '0) begin
                        out_q   <= acc_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        stage_q <= stage_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_multicycle_left_shifter.sv
module tb_multicycle_left_shifter;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        flush;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    multicycle_left_shifter #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .flush   (flush),
        .data    (data),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one operation and follows it to its done pulse. Optionally scrambles
    // the inputs (including start) while the shift is in progress.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] exp, input bit scramble);
        int busy_cnt;
        int early_done;
        busy_cnt   = 0;
        early_done = 0;
        start = 1'b1;
        data  = d;
        shamt = s;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy) busy_cnt++;
            if (done) early_done++;
            if (scramble) begin
                data  = $urandom;
                shamt = 5'($urandom);
                start = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd5);
        check({tag, " early_done"}, 32'(early_done), 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, " out"}, out, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  rs;
        logic [31:0] prior;
        int          done_seen;

        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        data    = '0;
        shamt   = '0;
        tick();
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset out", out, 32'd0);
        reset_n = 1'b1;
        tick();

        run_op("one_sh31", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_out_hold", out, 32'h8000_0000);

        run_op("dead_sh0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
        tick();
        run_op("ffff_sh4", 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0, 1'b0);
        tick();
        run_op("abcd_sh17", 32'h0000_ABCD, 5'd17, 32'h579A_0000, 1'b1);
        tick();

        // Back-to-back: each op is issued straight from the DONE cycle.
        run_op("b2b_0", 32'h1234_5678, 5'd8, 32'h3456_7800, 1'b0);
        run_op("b2b_1", 32'h8765_4321, 5'd1, 32'h0ECA_8642, 1'b0);
        run_op("b2b_2", 32'h0000_00FF, 5'd28, 32'hF000_0000, 1'b0);
        tick();

        // Asynchronous reset in the middle of a shift.
        start = 1'b1;
        data  = 32'h0000_0003;
        shamt = 5'd2;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check("async_rst out", out, 32'd0);
        check("async_rst busy", {31'd0, busy}, 32'd0);
        check("async_rst done", {31'd0, done}, 32'd0);
        tick();
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("async_rst no_done", 32'(done_seen), 32'd0);

        // Flush mid-shift keeps the previous result.
        run_op("pre_flush", 32'h0000_0F0F, 5'd16, 32'h0F0F_0000, 1'b0);
        prior = 32'h0F0F_0000;
        tick();
        start = 1'b1;
        data  = 32'hFFFF_FFFF;
        shamt = 5'd3;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        check("flush out", out, prior);
        done_seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("flush no_done", 32'(done_seen), 32'd0);
        check("flush out_hold", out, prior);

        // Flush wins over start on the same edge.
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_prio busy", {31'd0, busy}, 32'd0);
        tick();

        for (int n = 0; n < 1000; n++) begin
            rd = $urandom;
            rs = 5'($urandom);
            run_op("sweep", rd, rs, rd << rs, 1'b0);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
